// File: rtl/mem_arbiter_if.sv
// Requester A/B handshake signals and the single-port memory bus, bundled for mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_ready;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_ready;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  b_lock;

    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ready, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata, b_lock,
        output b_ready, b_rvalid, b_rdata,
        output mem_write_enable, mem_address, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ready, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata, b_lock,
        input  b_ready, b_rvalid, b_rdata,
        input  mem_write_enable, mem_address, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between requesters A and B,
// with a B bus lock and a two-cycle held-address read returning registered data per port.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_arbiter_if.slave    bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RD_HOLD = 1'b1} state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    state_t                state_r, state_nxt_s;
    logic                  last_grant_r;
    logic                  locked_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic                  rd_port_r;
    logic                  a_rvalid_r, b_rvalid_r;
    logic [DATA_WIDTH-1:0] a_rdata_r, b_rdata_r;

    logic                  win_a_s, win_b_s;
    logic                  a_ready_s, b_ready_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_din_s;

    // Winner selection; only an IDLE cycle out of reset can grant anyone.
    always_comb begin
        win_a_s = 1'b0;
        win_b_s = 1'b0;
        if (rst_n && (state_r == ST_IDLE)) begin
            if (locked_r) begin
                win_b_s = bus.b_req;
            end else if (bus.a_req && bus.b_req) begin
                win_a_s = (last_grant_r == GRANT_B);
                win_b_s = (last_grant_r == GRANT_A);
            end else begin
                win_a_s = bus.a_req;
                win_b_s = bus.b_req;
            end
        end else begin
            win_a_s = 1'b0;
            win_b_s = 1'b0;
        end
    end

    // Next state and memory-side / ready outputs.
    always_comb begin
        state_nxt_s = state_r;
        a_ready_s   = 1'b0;
        b_ready_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_WIDTH{1'b0}};
        mem_din_s   = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (win_a_s) begin
                    a_ready_s   = 1'b1;
                    mem_addr_s  = bus.a_addr;
                    mem_din_s   = bus.a_wdata;
                    mem_we_s    = bus.a_we;
                    state_nxt_s = bus.a_we ? ST_IDLE : ST_RD_HOLD;
                end else if (win_b_s) begin
                    b_ready_s   = 1'b1;
                    mem_addr_s  = bus.b_addr;
                    mem_din_s   = bus.b_wdata;
                    mem_we_s    = bus.b_we;
                    state_nxt_s = bus.b_we ? ST_IDLE : ST_RD_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_HOLD: begin
                mem_addr_s  = rd_addr_r;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, grant history, lock and read response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= GRANT_B;
            locked_r     <= 1'b0;
            rd_addr_r    <= {ADDR_WIDTH{1'b0}};
            rd_port_r    <= GRANT_A;
            a_rvalid_r   <= 1'b0;
            b_rvalid_r   <= 1'b0;
            a_rdata_r    <= {DATA_WIDTH{1'b0}};
            b_rdata_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
            if (win_a_s) begin
                last_grant_r <= GRANT_A;
                rd_addr_r    <= bus.a_addr;
                rd_port_r    <= GRANT_A;
            end else if (win_b_s) begin
                last_grant_r <= GRANT_B;
                rd_addr_r    <= bus.b_addr;
                rd_port_r    <= GRANT_B;
            end
            // A locked B accept wins over the idle-cycle release.
            if (win_b_s && bus.b_lock) begin
                locked_r <= 1'b1;
            end else if ((state_r == ST_IDLE) && !bus.b_lock) begin
                locked_r <= 1'b0;
            end
            if (state_r == ST_RD_HOLD) begin
                if (rd_port_r == GRANT_A) begin
                    a_rdata_r  <= bus.mem_data_out;
                    a_rvalid_r <= 1'b1;
                end else begin
                    b_rdata_r  <= bus.mem_data_out;
                    b_rvalid_r <= 1'b1;
                end
            end
        end
    end

    assign bus.a_ready          = a_ready_s;
    assign bus.b_ready          = b_ready_s;
    assign bus.mem_write_enable = mem_we_s;
    assign bus.mem_address      = mem_addr_s;
    assign bus.mem_data_in      = mem_din_s;
    assign bus.a_rvalid         = a_rvalid_r;
    assign bus.b_rvalid         = b_rvalid_r;
    assign bus.a_rdata          = a_rdata_r;
    assign bus.b_rdata          = b_rdata_r;
endmodule
